alu_pipe_param: RTL

- Parametrised successor to the 4-bit fixed-sequence ALU.
- Adds a configurable operand width, an 8-operation set and a negative flag.
- Adds valid/ready handshakes on input and output, with output backpressure.
- Sits between an operand source and a result consumer in the datapath test harness. Runs an IDLE/EXEC/WB sequence only when a transaction is presented.

---
 rtl/alu_pipe_param.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe_param.sv
// Parametrised three-phase (IDLE/EXEC/WB) ALU with valid/ready handshakes and a completed-transaction counter.
// Optional build macro ALU_SAT_EN: signed saturation of ADD/SUB results on overflow.
module alu_pipe_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ASR = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, zero_q, overflow_q, negative_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept_s;
    logic             big_shift_s;
    logic [WIDTH:0]   sum_s, diff_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_v_s;

    assign accept_s    = in_valid && (state_q == S_IDLE);
    assign sum_s       = {1'b0, a_q} + {1'b0, b_q};
    assign diff_s      = {1'b0, a_q} - {1'b0, b_q};
    assign big_shift_s = (32'(b_q) >= 32'(WIDTH));

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_EXEC;
                else          state_d = S_IDLE;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                if (out_ready) state_d = S_IDLE;
                else           state_d = S_WB;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operation datapath working on the latched operands.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = diff_s[WIDTH];
                alu_v_s   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res_s = a_q & b_q;
            OP_OR:  alu_res_s = a_q | b_q;
            OP_XOR: alu_res_s = a_q ^ b_q;
            OP_SHL: begin
                if (big_shift_s) alu_res_s = {WIDTH{1'b0}};
                else             alu_res_s = a_q << b_q;
            end
            OP_SHR: begin
                if (big_shift_s) alu_res_s = {WIDTH{1'b0}};
                else             alu_res_s = a_q >> b_q;
            end
            OP_ASR: begin
                if (big_shift_s) alu_res_s = {WIDTH{a_q[WIDTH-1]}};
                else             alu_res_s = $signed(a_q) >>> b_q;
            end
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction for both ADD and SUB follows the sign of a.
        if (alu_v_s) begin
            if (a_q[WIDTH-1]) alu_res_s = {1'b1, {(WIDTH-1){1'b0}}};
            else              alu_res_s = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            alu_res_s = alu_res_s;
        end
`endif
    end

    // State and operand capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

    // Result/flag registers loaded in EXEC, plus completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= {WIDTH{1'b0}};
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            if (state_q == S_EXEC) begin
                result_q   <= alu_res_s;
                carry_q    <= alu_c_s;
                zero_q     <= (alu_res_s == {WIDTH{1'b0}});
                overflow_q <= alu_v_s;
                negative_q <= alu_res_s[WIDTH-1];
            end
            if ((state_q == S_WB) && out_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_WB);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign txn_count = cnt_q;

endmodule
